burst_packer: RTL and testbench

//  Packs 16-bit fixed-point lanes from a 32-bit pipe stream (okBTPipeIn ep_write/ep_dataout)

---
 rtl/burst_packer.sv | 150 +++++++++++++++
 tb/tb_burst_packer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_packer.sv
// Burst packer: gathers 16-bit lanes from a 32-bit word stream into BURST_LEN-lane words
// and issues one BRAM write per full burst. Supports dual-lane input, zero-pad flush,
// a burst-target done flag and a sticky overflow flag.
module burst_packer #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      dual,
  input  logic [15:0]               target_bursts,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [31:0]               in_data,
  output logic                      in_ready,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [16*BURST_LEN-1:0]   ram_data,
  output logic [15:0]               burst_count,
  output logic                      done,
  output logic                      overflow
);

  localparam int unsigned DW = 16 * BURST_LEN;
  localparam int unsigned CW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {StFill, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       lane_q, lane_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DW-1:0]       data_q, data_d;
  logic [15:0]         bcount_q, bcount_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  // Scratch for shifting new lanes in at the MSB end; works down to BURST_LEN == 2.
  logic [DW+31:0]      cat32;
  logic [DW+15:0]      cat16;
  logic [DW-1:0]       lane_v;
  logic [CW-1:0]       cnt_v;

  assign in_ready    = (state_q == StFill);
  assign ram_wr_en   = wr_en_q;
  assign ram_addr    = addr_q;
  assign ram_data    = data_q;
  assign burst_count = bcount_q;
  assign done        = done_q;
  assign overflow    = ovf_q;

  // Next-state: lane packing, flush padding, write issue, counters and flags.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    bcount_d = bcount_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    cat32    = {in_data, lane_q};
    cat16    = {in_data[15:0], lane_q};
    lane_v   = lane_q;
    cnt_v    = cnt_q;

    if (in_valid && !in_ready) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          if (dual) begin
            lane_v = cat32[DW+31:32];
            cnt_v  = cnt_q + CW'(2);
          end else begin
            lane_v = cat16[DW+15:16];
            cnt_v  = cnt_q + CW'(1);
          end
        end
        // Flush is evaluated after the same-cycle accept.
        if (cnt_v == CW'(BURST_LEN)) begin
          data_d  = lane_v;
          wr_en_d = 1'b1;
          cnt_v   = '0;
        end else if (flush && (cnt_v != '0)) begin
          state_d = StFlush;
        end
        lane_d = lane_v;
        cnt_d  = cnt_v;
      end
      StFlush: begin
        cat16  = {16'h0000, lane_q};
        lane_d = cat16[DW+15:16];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_d == CW'(BURST_LEN)) begin
          data_d  = lane_d;
          wr_en_d = 1'b1;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StDone: begin
      end
      default: state_d = StFill;
    endcase

    // Address and burst count advance in the cycle of the write pulse.
    if (wr_en_q) begin
      addr_d = addr_q + ADDR_W'(1);
      if (bcount_q != 16'hFFFF) begin
        bcount_d = bcount_q + 16'd1;
      end
      if ((target_bursts != 16'd0) && (bcount_d == target_bursts)) begin
        state_d = StDone;
        done_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous reset / soft clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q  <= StFill;
      lane_q   <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      bcount_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      bcount_q <= bcount_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_burst_packer.sv
// Self-checking bench for burst_packer: a lane model fills a scoreboard of expected
// BRAM writes; a negedge monitor pops and compares each write pulse.
module tb_burst_packer;

  localparam int unsigned BL = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16 * BL;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          dual;
  logic [15:0]   target_bursts;
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [15:0]   burst_count;
  logic          done;
  logic          overflow;

  burst_packer #(
    .BURST_LEN (BL),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .dual          (dual),
    .target_bursts (target_bursts),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .ram_wr_en     (ram_wr_en),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .burst_count   (burst_count),
    .done          (done),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] lanes_m[$];
  int          addr_m;
  int          addr_log[$];
  int          n_tests;
  int          n_fail;
  exp_t        mon_e;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    lanes_m.delete();
    addr_m = 0;
  endtask

  task automatic model_lane(input logic [15:0] l);
    exp_t e;
    lanes_m.push_back(l);
    if (lanes_m.size() == BL) begin
      e.data = '0;
      for (int i = 0; i < BL; i++) e.data[16*i +: 16] = lanes_m[i];
      e.addr = AW'(addr_m);
      sb.push_back(e);
      addr_m = (addr_m + 1) % (1 << AW);
      lanes_m.delete();
    end
  endtask

  task automatic model_word(input logic [31:0] w, input logic d);
    model_lane(w[15:0]);
    if (d) model_lane(w[31:16]);
  endtask

  task automatic model_flush();
    while (lanes_m.size() != 0) model_lane(16'h0000);
  endtask

  // Drive one word (held valid for one edge) and record it in the model.
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    model_word(w, dual);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset(input logic use_clr);
    idle();
    if (use_clr) clr = 1'b1;
    else rst = 1'b1;
    step();
    rst = 1'b0;
    clr = 1'b0;
    model_reset();
    addr_log.delete();
  endtask

  // Bounded wait for every expected write to appear.
  task automatic drain(input string tag);
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    check(tag, DW'(sb.size()), '0);
    sb.delete();
  endtask

  // Monitor: every write pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ram_wr_en) begin
      addr_log.push_back(int'(ram_addr));
      if (sb.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", DW'(ram_addr), DW'(mon_e.addr));
        check("wr_data", ram_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    int lo;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b0;
    clr           = 1'b0;
    dual          = 1'b0;
    target_bursts = 16'd0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    model_reset();
    do_reset(1'b0);

    // Reset state
    check("rst_wr_en", DW'(ram_wr_en), 0);
    check("rst_addr", DW'(ram_addr), 0);
    check("rst_data", ram_data, 0);
    check("rst_count", DW'(burst_count), 0);
    check("rst_done", DW'(done), 0);
    check("rst_ovf", DW'(overflow), 0);
    check("rst_ready", DW'(in_ready), 1);

    // T1: single-lane, 16 back-to-back words
    stalls = 0;
    for (int i = 1; i <= 16; i++) begin
      if (!in_ready) stalls++;
      send(32'(i));
    end
    idle();
    drain("t1_drain");
    check("t1_stalls", DW'(stalls), 0);
    check("t1_count", DW'(burst_count), 2);
    check("t1_npulse", DW'(addr_log.size()), 2);

    // T2: dual-lane, pulse in the cycle after the 4th word
    do_reset(1'b0);
    dual = 1'b1;
    send(32'h0002_0001);
    send(32'h0004_0003);
    send(32'h0006_0005);
    check("t2_no_early", DW'(ram_wr_en), 0);
    send(32'h0008_0007);
    check("t2_pulse_cycle", DW'(ram_wr_en), 1);
    check("t2_data_const", ram_data,
          {16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1});
    idle();
    drain("t2_drain");
    dual = 1'b0;

    // T3: three lanes then flush; then a no-op flush
    do_reset(1'b0);
    send(32'h000A);
    send(32'h000B);
    send(32'h000C);
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    model_flush();
    lo = 0;
    for (int i = 0; i < 8; i++) begin
      if (!in_ready) lo++;
      step();
    end
    check("t3_ready_low", DW'(lo), 5);
    drain("t3_drain");
    check("t3_count", DW'(burst_count), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_noop_ready", DW'(in_ready), 1);
    for (int i = 0; i < 10; i++) step();
    check("t3_noop_count", DW'(burst_count), 1);

    // T4: target of 2 bursts with 20 words offered
    target_bursts = 16'd2;
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      if (i < 16) model_word(in_data, 1'b0);
      step();
      if (i == 16) begin
        check("t4_done_set", DW'(done), 1);
        check("t4_ready_low", DW'(in_ready), 0);
        check("t4_ovf_pre", DW'(overflow), 0);
      end
      if (i == 17) check("t4_ovf_set", DW'(overflow), 1);
    end
    idle();
    drain("t4_drain");
    check("t4_count", DW'(burst_count), 2);
    check("t4_done", DW'(done), 1);
    check("t4_ovf", DW'(overflow), 1);
    check("t4_npulse", DW'(addr_log.size()), 2);
    target_bursts = 16'd0;

    // T5: address wrap with a 2-bit address
    do_reset(1'b1);
    check("t5_clr_done", DW'(done), 0);
    dual = 1'b1;
    for (int i = 0; i < 20; i++) send({16'(2 * i + 1), 16'(2 * i)});
    idle();
    drain("t5_drain");
    check("t5_count", DW'(burst_count), 5);
    check("t5_npulse", DW'(addr_log.size()), 5);
    if (addr_log.size() == 5) begin
      check("t5_a0", DW'(addr_log[0]), 0);
      check("t5_a3", DW'(addr_log[3]), 3);
      check("t5_a4", DW'(addr_log[4]), 0);
    end
    dual = 1'b0;

    // T6: rst and clr mid-burst discard partial lanes
    for (int k = 0; k < 2; k++) begin
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) send(32'h0000_0F00 + 32'(i));
      do_reset(k == 1);
      for (int i = 0; i < 8; i++) send(32'h0000_0100 + 32'(i));
      idle();
      drain("t6_drain");
      check("t6_count", DW'(burst_count), 1);
      check("t6_addr0", DW'(addr_log.size() > 0 ? addr_log[0] : -1), 0);
    end

    // Reset coinciding with the completing word cancels the write
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) send(32'(i + 1));
    in_valid = 1'b1;
    in_data  = 32'h8;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    idle();
    model_reset();
    for (int i = 0; i < 5; i++) step();
    check("t6_cancel_count", DW'(burst_count), 0);
    check("t6_cancel_npulse", DW'(addr_log.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
